// File: rtl/uart_alu_interface.sv
`timescale 1ns/1ps
// uart_alu_interface
// Sequences one RX->ALU->TX transaction: collects operand A, operand B and the
// opcode from three received bytes, drives the external combinational ALU,
// then hands the ALU result to the UART transmitter with a one-clock start.
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_rx_done     receiver byte-done level (one accept event per rising edge)
//   i_rx_data     received byte, valid while i_rx_done is high
//   i_alu_result  combinational ALU result of o_alu_a/o_alu_b/o_alu_op
//   i_tx_done     transmitter byte-done level (rising edge ends WAIT_TX)
//   o_alu_a       registered operand A
//   o_alu_b       registered operand B
//   o_alu_op      registered opcode (low NB_OP bits of the third byte)
//   o_tx_data     registered byte to transmit, held until the next SEND
//   o_tx_start    one-clock transmit start pulse
//   o_overrun     sticky flag: a byte arrived while busy and was dropped
//
// Configuration
//   INTERFACE_TIMEOUT_EN  when defined, a partial frame (WAIT_B/WAIT_OP) idle
//                         for TIMEOUT_CYCLES clocks is abandoned back to WAIT_A.
module uart_alu_interface #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               rx_done_q;
    logic               tx_done_q;
    logic               rx_ev_c;
    logic               tx_ev_c;
    logic               timeout_c;
    logic [NB_DATA-1:0] alu_a_d;
    logic [NB_DATA-1:0] alu_b_d;
    logic [NB_OP-1:0]   alu_op_d;
    logic [NB_DATA-1:0] tx_data_d;
    logic               tx_start_d;
    logic               overrun_d;

    // Rising-edge detection: one event per byte however long done stays high
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_done_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            rx_done_q <= i_rx_done;
            tx_done_q <= i_tx_done;
        end
    end

    assign rx_ev_c = i_rx_done & ~rx_done_q;
    assign tx_ev_c = i_tx_done & ~tx_done_q;

`ifdef INTERFACE_TIMEOUT_EN
    localparam int unsigned NB_TMR = $clog2(TIMEOUT_CYCLES + 1);

    logic [NB_TMR-1:0] idle_cnt_q;
    logic              collecting_c;

    assign collecting_c = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign timeout_c    = collecting_c && !rx_ev_c
                          && (idle_cnt_q == NB_TMR'(TIMEOUT_CYCLES));

    // Idle clocks inside a partial frame; zero outside it, so entry starts at 0
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            idle_cnt_q <= '0;
        end else if (!collecting_c || rx_ev_c || timeout_c) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + NB_TMR'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_alu_a    <= alu_a_d;
            o_alu_b    <= alu_b_d;
            o_alu_op   <= alu_op_d;
            o_tx_data  <= tx_data_d;
            o_tx_start <= tx_start_d;
            o_overrun  <= overrun_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d    = state_q;
        alu_a_d    = o_alu_a;
        alu_b_d    = o_alu_b;
        alu_op_d   = o_alu_op;
        tx_data_d  = o_tx_data;
        tx_start_d = 1'b0;
        overrun_d  = o_overrun;
        case (state_q)
            WAIT_A: begin
                if (rx_ev_c) begin
                    alu_a_d = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_ev_c) begin
                    alu_b_d = i_rx_data;
                    state_d = WAIT_OP;
                end else if (timeout_c) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (rx_ev_c) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = SEND;
                end else if (timeout_c) begin
                    state_d = WAIT_A;
                end
            end
            SEND: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
                if (rx_ev_c) begin
                    overrun_d = 1'b1;
                end
            end
            WAIT_TX: begin
                // A byte arriving with the tx edge is still dropped and flagged
                if (rx_ev_c) begin
                    overrun_d = 1'b1;
                end
                if (tx_ev_c) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
`timescale 1ns/1ps
// Testbench for uart_alu_interface: directed byte frames against a
// transaction-level model, plus literal expectations for the key scenarios.
module tb_uart_alu_interface;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_overrun;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    bit chk_on = 1'b0;

    uart_alu_interface #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_overrun    (o_overrun)
    );

    // ALU in the environment: ADD
    assign i_alu_result = 8'(o_alu_a + o_alu_b);

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: frame byte index, pending send slot, busy until tx done
    int         m_idx = 0;
    bit         m_send = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_prx = 1'b0;
    bit         m_ptx = 1'b0;
    int         m_idle = 0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [5:0] m_op = 6'h00;
    logic [7:0] m_tx = 8'h00;
    bit         m_start = 1'b0;
    bit         m_ovr = 1'b0;

    always @(posedge i_clock or negedge i_reset) begin
        bit rx_ev;
        bit tx_ev;
        if (!i_reset) begin
            m_idx = 0; m_send = 0; m_busy = 0; m_prx = 0; m_ptx = 0; m_idle = 0;
            m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00; m_start = 0; m_ovr = 0;
        end else begin
            rx_ev = i_rx_done && !m_prx;
            tx_ev = i_tx_done && !m_ptx;
            m_prx = i_rx_done;
            m_ptx = i_tx_done;
            m_start = 0;
            if (m_send) begin
                m_start = 1;
                m_tx = 8'(m_a + m_b);
                m_send = 0;
                m_busy = 1;
                if (rx_ev) m_ovr = 1;
            end else if (m_busy) begin
                if (rx_ev) m_ovr = 1;
                if (tx_ev) m_busy = 0;
            end else if (rx_ev) begin
                m_idle = 0;
                if (m_idx == 0) m_a = i_rx_data;
                else if (m_idx == 1) m_b = i_rx_data;
                else m_op = i_rx_data[5:0];
                m_idx = m_idx + 1;
                if (m_idx == 3) begin
                    m_idx = 0;
                    m_send = 1;
                end
            end else if (m_idx > 0) begin
`ifdef INTERFACE_TIMEOUT_EN
                if (m_idle == 50) begin
                    m_idx = 0;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
`endif
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge i_clock) begin
        if (chk_on) begin
            check("alu_a", 32'(o_alu_a), 32'(m_a));
            check("alu_b", 32'(o_alu_b), 32'(m_b));
            check("alu_op", 32'(o_alu_op), 32'(m_op));
            check("tx_data", 32'(o_tx_data), 32'(m_tx));
            check("tx_start", 32'(o_tx_start), 32'(m_start));
            check("overrun", 32'(o_overrun), 32'(m_ovr));
        end
        if (o_tx_start === 1'b1) n_start++;
    end

    // Called at posedge+1; leaves at posedge+1
    task automatic send_byte(input logic [7:0] b, input int hold);
        i_rx_data = b;
        i_rx_done = 1'b1;
        repeat (hold) @(posedge i_clock);
        #1;
        i_rx_done = 1'b0;
        @(posedge i_clock);
        #1;
    endtask

    task automatic tx_pulse();
        i_tx_done = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        i_tx_done = 1'b0;
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"}, 32'(o_alu_a), 32'h0);
        check({tag, "_alu_b"}, 32'(o_alu_b), 32'h0);
        check({tag, "_alu_op"}, 32'(o_alu_op), 32'h0);
        check({tag, "_tx_data"}, 32'(o_tx_data), 32'h0);
        check({tag, "_tx_start"}, 32'(o_tx_start), 32'h0);
        check({tag, "_overrun"}, 32'(o_overrun), 32'h0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge i_clock);
        #1;
        check_all_zero("reset");
        i_reset = 1'b1;
        chk_on = 1'b1;
        idle(2);

        // Basic frame, long done per byte
        send_byte(8'h05, 16);
        send_byte(8'h03, 16);
        send_byte(8'h20, 16);
        idle(3);
        check("f1_alu_a", 32'(o_alu_a), 32'h05);
        check("f1_alu_b", 32'(o_alu_b), 32'h03);
        check("f1_alu_op", 32'(o_alu_op), 32'h20);
        check("f1_tx_data", 32'(o_tx_data), 32'h08);
        check("f1_start_count", 32'(n_start), 32'd1);

        // Overrun while waiting for the transmitter
        send_byte(8'h11, 4);
        check("ovr_flag", 32'(o_overrun), 32'h1);
        check("ovr_alu_a", 32'(o_alu_a), 32'h05);
        check("ovr_alu_b", 32'(o_alu_b), 32'h03);
        check("ovr_start_count", 32'(n_start), 32'd1);
        tx_pulse();

        // Done held 200 clocks: one byte only
        send_byte(8'hAA, 200);
        check("long_alu_a", 32'(o_alu_a), 32'hAA);
        check("long_alu_b", 32'(o_alu_b), 32'h03);
        send_byte(8'h10, 3);
        check("long_next_alu_b", 32'(o_alu_b), 32'h10);
        check("long_next_alu_op", 32'(o_alu_op), 32'h20);

        // Latency: opcode event in cycle N, start only in N+2
        i_rx_data = 8'h20;
        i_rx_done = 1'b1;
        @(negedge i_clock);
        check("lat_N", 32'(o_tx_start), 32'h0);
        @(negedge i_clock);
        check("lat_N1", 32'(o_tx_start), 32'h0);
        @(negedge i_clock);
        check("lat_N2", 32'(o_tx_start), 32'h1);
        check("lat_N2_data", 32'(o_tx_data), 32'hBA);
        @(negedge i_clock);
        check("lat_N3", 32'(o_tx_start), 32'h0);
        @(posedge i_clock);
        #1;
        i_rx_done = 1'b0;
        idle(2);
        tx_pulse();

        // Reset in the middle of a frame
        send_byte(8'h07, 2);
        send_byte(8'h09, 2);
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;
        check_all_zero("midrst");
        i_reset = 1'b1;
        idle(1);
        send_byte(8'h01, 2);
        send_byte(8'h02, 2);
        send_byte(8'h20, 2);
        idle(2);
        check("midrst_tx_data", 32'(o_tx_data), 32'h03);
        check("midrst_alu_op", 32'(o_alu_op), 32'h20);
        tx_pulse();

`ifdef INTERFACE_TIMEOUT_EN
        // Partial frame abandoned after idle timeout
        send_byte(8'h05, 2);
        idle(60);
        send_byte(8'h06, 2);
        send_byte(8'h02, 2);
        send_byte(8'h22, 2);
        idle(2);
        check("to_alu_a", 32'(o_alu_a), 32'h06);
        check("to_alu_b", 32'(o_alu_b), 32'h02);
        check("to_alu_op", 32'(o_alu_op), 32'h22);
        check("to_tx_data", 32'(o_tx_data), 32'h08);
        tx_pulse();
`endif

        idle(3);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
